// File: rtl/sa_pkg.sv
// Shared definitions for the spatial-array control sequencer:
// field widths, control-word bit positions, the packed program
// entry layout and the sequencer FSM state encoding.
package sa_pkg;

    localparam int CTRL_WIDTH            = 9;
    localparam int WD_BUFFER_DEPTH       = 16;
    localparam int INPUT_BUFFER_DEPTH    = 2;
    localparam int PARTIALS_BUFFER_DEPTH = 2;
    localparam int PROG_DEPTH            = 32;
    localparam int REP_WIDTH             = 8;
    localparam int ITER_WIDTH            = 8;

    localparam int WD_IDX_W   = $clog2(WD_BUFFER_DEPTH);
    localparam int IN_IDX_W   = $clog2(INPUT_BUFFER_DEPTH);
    localparam int PART_IDX_W = $clog2(PARTIALS_BUFFER_DEPTH);
    localparam int PC_W       = $clog2(PROG_DEPTH);

    // Control word bit positions. Bits 0..4 are the cell mux selects,
    // bit 5 is spare, bits 6..8 are the buffer push-valid strobes.
    localparam int CTRL_MUX1      = 0;
    localparam int CTRL_MUX2      = 1;
    localparam int CTRL_MUX3      = 2;
    localparam int CTRL_MUX4      = 3;
    localparam int CTRL_MUX5      = 4;
    localparam int CTRL_SPARE     = 5;
    localparam int CTRL_WD_PUSH   = 6;
    localparam int CTRL_IN_PUSH   = 7;
    localparam int CTRL_PART_PUSH = 8;

    // One program entry, MSB first.
    typedef struct packed {
        logic                  last;
        logic [REP_WIDTH-1:0]  rep;
        logic [PART_IDX_W-1:0] part_idx;
        logic [IN_IDX_W-1:0]   in_idx;
        logic [WD_IDX_W-1:0]   wd_idx;
        logic                  add_sub;
        logic [CTRL_WIDTH-1:0] ctrl;
    } sa_prog_entry_t;

    localparam int ENTRY_W = $bits(sa_prog_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_seq_state_t;

    // Clears the three push-valid strobes, leaving selects untouched.
    function automatic logic [CTRL_WIDTH-1:0] ctrl_mask_push(input logic [CTRL_WIDTH-1:0] c);
        logic [CTRL_WIDTH-1:0] r;
        r                 = c;
        r[CTRL_WD_PUSH]   = 1'b0;
        r[CTRL_IN_PUSH]   = 1'b0;
        r[CTRL_PART_PUSH] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/sa_prog_mem.sv
// Program store for the sequencer: PROG_DEPTH x ENTRY_W register file
// with one synchronous write port, one combinational read port and a
// synchronous clear on reset.
module sa_prog_mem
    import sa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_q [PROG_DEPTH];
    logic [ENTRY_W-1:0] mem_d [PROG_DEPTH];

    // Next memory contents: unchanged except the addressed word on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage array, wiped to zero by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sa_ctrl_sequencer.sv
// Microprogrammed control sequencer for one spatial-array cell column.
// Steps through program entries, holding each for rep+1 live cycles,
// loops the program n_iter times and pulses done at the end.
// Optional feature macro: SA_SEQ_IDX_AUTOINC_EN -- when defined, the
// buffer pop indices advance by one on every live repeat cycle of an
// entry; otherwise they stay at the entry's base values.
module sa_ctrl_sequencer
    import sa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [PC_W-1:0]       prog_addr,
    input  logic [ENTRY_W-1:0]    prog_wdata,
    output logic                  prog_err,
    input  logic                  start,
    input  logic [PC_W-1:0]       start_pc,
    input  logic [ITER_WIDTH-1:0] n_iter,
    input  logic                  stall,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [WD_IDX_W-1:0]   wd_buffer_pop_index,
    output logic [IN_IDX_W-1:0]   input_buffer_pop_index,
    output logic [PART_IDX_W-1:0] partials_buffer_pop_index,
    output logic                  add_sub
);

    sa_seq_state_t         state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [PC_W-1:0]       start_pc_q, start_pc_d;
    logic [REP_WIDTH-1:0]  rep_cnt_q, rep_cnt_d;
    logic [REP_WIDTH-1:0]  cur_rep_q, cur_rep_d;
    logic                  cur_last_q, cur_last_d;
    logic [CTRL_WIDTH-1:0] cur_ctrl_q, cur_ctrl_d;
    logic [ITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
    logic [ITER_WIDTH-1:0] n_iter_q, n_iter_d;

    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [WD_IDX_W-1:0]   wd_idx_q, wd_idx_d;
    logic [IN_IDX_W-1:0]   in_idx_q, in_idx_d;
    logic [PART_IDX_W-1:0] part_idx_q, part_idx_d;
    logic                  add_sub_q, add_sub_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  prog_err_q, prog_err_d;

    logic                  mem_we;
    logic [PC_W-1:0]       mem_raddr;
    logic [ENTRY_W-1:0]    mem_rdata;
    sa_prog_entry_t        rd_entry;

    logic                  end_of_entry;
    logic [ITER_WIDTH-1:0] iter_limit;
    logic                  more_passes;
    logic [PC_W-1:0]       seq_pc;
    logic                  load_entry;

    // Writes land only while idle; anything else is dropped and flagged.
    assign mem_we = prog_we && (state_q == ST_IDLE);

    sa_prog_mem u_prog_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign rd_entry = sa_prog_entry_t'(mem_rdata);

    // Sequencing helpers: end of current entry, pass accounting, and the
    // address of the entry that follows (restart, wrap or increment).
    always_comb begin
        end_of_entry = (rep_cnt_q == cur_rep_q);
        iter_limit   = (n_iter_q == '0) ? '0 : (n_iter_q - ITER_WIDTH'(1));
        more_passes  = (iter_cnt_q < iter_limit);
        if (cur_last_q) begin
            seq_pc = start_pc_q;
        end else if (pc_q == PC_W'(PROG_DEPTH - 1)) begin
            seq_pc = '0;
        end else begin
            seq_pc = pc_q + PC_W'(1);
        end
        mem_raddr = (state_q == ST_IDLE) ? start_pc : seq_pc;
    end

    // FSM next-state, counters and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        start_pc_d = start_pc_q;
        rep_cnt_d  = rep_cnt_q;
        cur_rep_d  = cur_rep_q;
        cur_last_d = cur_last_q;
        cur_ctrl_d = cur_ctrl_q;
        iter_cnt_d = iter_cnt_q;
        n_iter_d   = n_iter_q;
        ctrl_d     = ctrl_q;
        wd_idx_d   = wd_idx_q;
        in_idx_d   = in_idx_q;
        part_idx_d = part_idx_q;
        add_sub_d  = add_sub_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        prog_err_d = prog_we && (state_q != ST_IDLE);
        load_entry = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    pc_d       = start_pc;
                    start_pc_d = start_pc;
                    n_iter_d   = n_iter;
                    iter_cnt_d = '0;
                    busy_d     = 1'b1;
                    load_entry = 1'b1;
                end
            end

            ST_RUN: begin
                if (stall) begin
                    ctrl_d = ctrl_mask_push(cur_ctrl_q);
                end else if (!end_of_entry) begin
                    rep_cnt_d = rep_cnt_q + REP_WIDTH'(1);
                    ctrl_d    = cur_ctrl_q;
`ifdef SA_SEQ_IDX_AUTOINC_EN
                    wd_idx_d   = wd_idx_q + WD_IDX_W'(1);
                    in_idx_d   = in_idx_q + IN_IDX_W'(1);
                    part_idx_d = part_idx_q + PART_IDX_W'(1);
`endif
                end else if (cur_last_q && !more_passes) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    ctrl_d     = '0;
                    wd_idx_d   = '0;
                    in_idx_d   = '0;
                    part_idx_d = '0;
                    add_sub_d  = 1'b0;
                end else begin
                    if (cur_last_q) begin
                        iter_cnt_d = iter_cnt_q + ITER_WIDTH'(1);
                    end
                    pc_d       = seq_pc;
                    load_entry = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_entry) begin
            rep_cnt_d  = '0;
            cur_rep_d  = rd_entry.rep;
            cur_last_d = rd_entry.last;
            cur_ctrl_d = rd_entry.ctrl;
            ctrl_d     = rd_entry.ctrl;
            wd_idx_d   = rd_entry.wd_idx;
            in_idx_d   = rd_entry.in_idx;
            part_idx_d = rd_entry.part_idx;
            add_sub_d  = rd_entry.add_sub;
        end

        if (abort) begin
            state_d    = ST_IDLE;
            rep_cnt_d  = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            ctrl_d     = '0;
            wd_idx_d   = '0;
            in_idx_d   = '0;
            part_idx_d = '0;
            add_sub_d  = 1'b0;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            start_pc_q <= '0;
            rep_cnt_q  <= '0;
            cur_rep_q  <= '0;
            cur_last_q <= 1'b0;
            cur_ctrl_q <= '0;
            iter_cnt_q <= '0;
            n_iter_q   <= '0;
            ctrl_q     <= '0;
            wd_idx_q   <= '0;
            in_idx_q   <= '0;
            part_idx_q <= '0;
            add_sub_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            start_pc_q <= start_pc_d;
            rep_cnt_q  <= rep_cnt_d;
            cur_rep_q  <= cur_rep_d;
            cur_last_q <= cur_last_d;
            cur_ctrl_q <= cur_ctrl_d;
            iter_cnt_q <= iter_cnt_d;
            n_iter_q   <= n_iter_d;
            ctrl_q     <= ctrl_d;
            wd_idx_q   <= wd_idx_d;
            in_idx_q   <= in_idx_d;
            part_idx_q <= part_idx_d;
            add_sub_q  <= add_sub_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            prog_err_q <= prog_err_d;
        end
    end

    assign ctrl                      = ctrl_q;
    assign wd_buffer_pop_index       = wd_idx_q;
    assign input_buffer_pop_index    = in_idx_q;
    assign partials_buffer_pop_index = part_idx_q;
    assign add_sub                   = add_sub_q;
    assign busy                      = busy_q;
    assign done                      = done_q;
    assign prog_err                  = prog_err_q;

endmodule

// File: tb/tb_sa_ctrl_sequencer.sv
// Self-checking bench for sa_ctrl_sequencer. Each scenario pushes the
// expected per-cycle output bundle onto a scoreboard queue, drives the
// run, and pops/compares one bundle per cycle on the falling edge.
module tb_sa_ctrl_sequencer;
    import sa_pkg::*;

`ifdef SA_SEQ_IDX_AUTOINC_EN
    localparam int AUTOINC = 1;
`else
    localparam int AUTOINC = 0;
`endif

    localparam logic [18:0] IDLE_B = 19'h00000;
    localparam logic [18:0] DONE_B = 19'h10000;
    localparam logic [18:0] BUSY_B = 19'h20000;
    localparam logic [18:0] PERR_B = 19'h40000;

    logic                  clk;
    logic                  rst;
    logic                  prog_we;
    logic [PC_W-1:0]       prog_addr;
    logic [ENTRY_W-1:0]    prog_wdata;
    logic                  prog_err;
    logic                  start;
    logic [PC_W-1:0]       start_pc;
    logic [ITER_WIDTH-1:0] n_iter;
    logic                  stall;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [WD_IDX_W-1:0]   wd_buffer_pop_index;
    logic [IN_IDX_W-1:0]   input_buffer_pop_index;
    logic [PART_IDX_W-1:0] partials_buffer_pop_index;
    logic                  add_sub;

    int n_cmp;
    int n_bad;
    logic [18:0] exp_q[$];

    sa_ctrl_sequencer dut (
        .clk                       (clk),
        .rst                       (rst),
        .prog_we                   (prog_we),
        .prog_addr                 (prog_addr),
        .prog_wdata                (prog_wdata),
        .prog_err                  (prog_err),
        .start                     (start),
        .start_pc                  (start_pc),
        .n_iter                    (n_iter),
        .stall                     (stall),
        .abort                     (abort),
        .busy                      (busy),
        .done                      (done),
        .ctrl                      (ctrl),
        .wd_buffer_pop_index       (wd_buffer_pop_index),
        .input_buffer_pop_index    (input_buffer_pop_index),
        .partials_buffer_pop_index (partials_buffer_pop_index),
        .add_sub                   (add_sub)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [18:0] obs();
        return {prog_err, busy, done, ctrl, wd_buffer_pop_index,
                input_buffer_pop_index, partials_buffer_pop_index, add_sub};
    endfunction

    function automatic sa_prog_entry_t ent(logic [8:0] c, logic [7:0] rep, logic last,
                                           logic [3:0] wd, logic in_i, logic pt, logic as);
        sa_prog_entry_t e;
        e.ctrl     = c;
        e.rep      = rep;
        e.last     = last;
        e.wd_idx   = wd;
        e.in_idx   = in_i;
        e.part_idx = pt;
        e.add_sub  = as;
        return e;
    endfunction

    // Expected bundle while an entry is on the outputs, 'step' live repeat
    // cycles into it, optionally with push strobes blanked by a stall.
    function automatic logic [18:0] mk_entry(sa_prog_entry_t e, int step, bit masked);
        logic [8:0] c;
        logic [3:0] wd;
        logic [0:0] ii;
        logic [0:0] pp;
        c  = masked ? (e.ctrl & 9'h03F) : e.ctrl;
        wd = e.wd_idx + 4'(step * AUTOINC);
        ii = e.in_idx + 1'(step * AUTOINC);
        pp = e.part_idx + 1'(step * AUTOINC);
        return {1'b0, 1'b1, 1'b0, c, wd, ii, pp, e.add_sub};
    endfunction

    task automatic write_entry(input logic [4:0] a, input sa_prog_entry_t e);
        @(negedge clk);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = e;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    task automatic drive_idle();
        start   = 1'b0;
        stall   = 1'b0;
        abort   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] got, expv;
        repeat (3) exp_q.push_back(IDLE_B);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL reset cyc %0d: got %h expected %h", j, got, expv);
            end
            if (j == 1) rst = 1'b0;
        end
    endtask

    task automatic test_single_entry();
        logic [18:0] got, expv;
        sa_prog_entry_t e;
        e = ent(9'h0C1, 8'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        write_entry(5'd0, e);
        for (int k = 0; k < 3; k++) exp_q.push_back(mk_entry(e, k, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd0; n_iter = 8'd1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL single_entry cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            if (j == 1) begin start = 1'b1; start_pc = 5'd5; end
            if (j == 3) start = 1'b1;
        end
    endtask

    task automatic test_multi_pass();
        logic [18:0] got, expv;
        sa_prog_entry_t e[3];
        e[0] = ent(9'h1C2, 8'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        e[1] = ent(9'h0A4, 8'd0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1);
        e[2] = ent(9'h148, 8'd0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) write_entry(5'(k), e[k]);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 3; k++) exp_q.push_back(mk_entry(e[k], 0, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd0; n_iter = 8'd3;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL multi_pass cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            if (j == 2) begin start = 1'b1; start_pc = 5'd1; end
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(mk_entry(e[k], 0, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        start = 1'b1; start_pc = 5'd0; n_iter = 8'd0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL n_iter_zero cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
        end
    endtask

    task automatic test_stall();
        logic [18:0] got, expv;
        sa_prog_entry_t e;
        int step_tab[7] = '{0, 1, 1, 1, 2, 3, 4};
        e = ent(9'h1FF, 8'd4, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
        write_entry(5'd4, e);
        for (int k = 0; k < 7; k++)
            exp_q.push_back(mk_entry(e, step_tab[k], (k == 2) || (k == 3)));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd4; n_iter = 8'd1;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL stall cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            if (j == 1 || j == 2) stall = 1'b1;
        end
    endtask

    task automatic test_abort();
        logic [18:0] got, expv;
        sa_prog_entry_t e;
        e = ent(9'h0C3, 8'd5, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1);
        write_entry(5'd8, e);
        exp_q.push_back(mk_entry(e, 0, 1'b0));
        exp_q.push_back(mk_entry(e, 1, 1'b0));
        repeat (4) exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd8; n_iter = 8'd1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL abort cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            if (j == 1) begin abort = 1'b1; start = 1'b1; end
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(mk_entry(e, k, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        start = 1'b1; start_pc = 5'd8; n_iter = 8'd1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL restart cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
        end
    endtask

    task automatic test_prog_err_wrap();
        logic [18:0] got, expv;
        sa_prog_entry_t e31, e0, bad;
        e31 = ent(9'h041, 8'd1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1);
        e0  = ent(9'h085, 8'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        bad = ent(9'h1AA, 8'd3, 1'b0, 4'd15, 1'b1, 1'b1, 1'b1);
        write_entry(5'd31, e31);
        write_entry(5'd0, e0);
        exp_q.push_back(mk_entry(e31, 0, 1'b0));
        exp_q.push_back(mk_entry(e31, 1, 1'b0) | PERR_B);
        exp_q.push_back(mk_entry(e0, 0, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B | PERR_B);
        exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd31; n_iter = 8'd1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL prog_err_wrap cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            if (j == 0 || j == 3) begin
                prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = bad;
            end
        end
        exp_q.push_back(mk_entry(e0, 0, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        start = 1'b1; start_pc = 5'd0; n_iter = 8'd1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL readback cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
        end
    endtask

    task automatic test_autoinc();
        logic [18:0] got, expv;
        sa_prog_entry_t e;
        e = ent(9'h0E0, 8'd3, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0);
        write_entry(5'd10, e);
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_entry(e, k, 1'b0));
        exp_q.push_back(DONE_B);
        exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd10; n_iter = 8'd1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL autoinc cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [18:0] got, expv;
        sa_prog_entry_t e;
        e = ent(9'h1C5, 8'd20, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        write_entry(5'd12, e);
        exp_q.push_back(mk_entry(e, 0, 1'b0));
        exp_q.push_back(mk_entry(e, 1, 1'b0));
        repeat (4) exp_q.push_back(IDLE_B);
        @(negedge clk);
        start = 1'b1; start_pc = 5'd12; n_iter = 8'd2;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL reset_mid_run cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            rst = (j == 1);
        end
        // Reset wiped the program, so a run sees only zero entries.
        repeat (4) exp_q.push_back(BUSY_B);
        exp_q.push_back(IDLE_B);
        exp_q.push_back(IDLE_B);
        start = 1'b1; start_pc = 5'd12; n_iter = 8'd1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            got  = obs();
            expv = exp_q.pop_front();
            n_cmp++;
            if (got !== expv) begin
                n_bad++;
                $display("[TB] FAIL cleared_mem cyc %0d: got %h expected %h", j, got, expv);
            end
            drive_idle();
            if (j == 3) abort = 1'b1;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        start      = 1'b0;
        start_pc   = '0;
        n_iter     = '0;
        stall      = 1'b0;
        abort      = 1'b0;

        test_reset();
        test_single_entry();
        test_multi_pass();
        test_stall();
        test_abort();
        test_prog_err_wrap();
        test_autoinc();
        test_reset_mid_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
